// File: rtl/microwave_ctrl_p_if.sv
// Signal bundle between the microwave controller and its keypad/buttons/display.
// The controller uses the slave modport; whoever drives the buttons uses master.
interface microwave_ctrl_p_if #(
  parameter int DIGITS = 4
);
  logic [9:0]          keypad;
  logic [3:0]          power_level;
  logic                startn;
  logic                stopn;
  logic                clearn;
  logic                door_closed;
  logic [4*DIGITS-1:0] time_bcd;
  logic                mag_on;
  logic                cooking;
  logic                paused;
  logic                beep;
  logic [1:0]          state_dbg;

  modport master (
    output keypad, power_level, startn, stopn, clearn, door_closed,
    input  time_bcd, mag_on, cooking, paused, beep, state_dbg
  );

  modport slave (
    input  keypad, power_level, startn, stopn, clearn, door_closed,
    output time_bcd, mag_on, cooking, paused, beep, state_dbg
  );
endinterface

// File: rtl/microwave_ctrl_p.sv
// Microwave controller: keypad time entry, BCD min:sec countdown, door-interlocked
// start/stop/clear/pause sequencing, duty-cycled magnetron power and end-of-cook beep.
module microwave_ctrl_p #(
  parameter int DIGITS          = 4,
  parameter int TICK_DIV        = 50_000_000,
  parameter int POWER_LEVELS    = 10,
  parameter int BEEP_TICKS      = 3,
  parameter int QUICK_SECS_TENS = 3
) (
  input  logic             clock,
  input  logic             reset,
  microwave_ctrl_p_if.slave bus
);

  localparam int NW = 4 * DIGITS;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS + 1) : 1;
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   time_q, time_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [LW-1:0]   phase_q, phase_d;
  logic [LW-1:0]   level_q, level_d;
  logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
  logic            start_prev_q, stop_prev_q, clear_prev_q, key_prev_q;
  logic            mag_q, cooking_q, paused_q, beep_q;

  logic            start_p, stop_p, clear_p, key_p;
  logic [3:0]      key_digit;
  logic            tick_wrap;
  logic [NW-1:0]   time_dec;
  logic [NW-1:0]   quick_time;
  logic [LW-1:0]   level_req;
  logic [LW-1:0]   phase_next;

  // Seconds tens borrow to 5, every other digit to 9; entries like 1:75 just count down.
  function automatic logic [NW-1:0] bcd_dec(input logic [NW-1:0] t);
    logic [NW-1:0] r;
    logic          borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (t[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    key_digit = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (bus.keypad[i]) key_digit = 4'(i);
    end
  end

  assign start_p    = start_prev_q & ~bus.startn;
  assign stop_p     = stop_prev_q  & ~bus.stopn;
  assign clear_p    = clear_prev_q & ~bus.clearn;
  assign key_p      = (|bus.keypad) & ~key_prev_q;
  assign tick_wrap  = (tick_q == TW'(TICK_DIV - 1));
  assign time_dec   = bcd_dec(time_q);
  assign level_req  = (int'(bus.power_level) > POWER_LEVELS) ? LW'(POWER_LEVELS)
                                                            : LW'(bus.power_level);
  assign phase_next = (phase_q == LW'(POWER_LEVELS - 1)) ? '0 : phase_q + LW'(1);

  always_comb begin
    quick_time      = '0;
    quick_time[7:4] = 4'(QUICK_SECS_TENS);
  end

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    tick_d     = tick_q;
    phase_d    = phase_q;
    level_d    = level_q;
    beep_cnt_d = beep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear_p || stop_p) begin
          time_d = '0;
        end else if (start_p && bus.door_closed) begin
          tick_d  = '0;
          phase_d = '0;
          state_d = S_COOK;
          if (time_q == '0) begin
            time_d  = quick_time;
            level_d = LW'(POWER_LEVELS);
          end else begin
            level_d = level_req;
          end
        end else if (key_p) begin
          time_d = {time_q[NW-5:0], key_digit};
        end
      end
      S_COOK: begin
        if (clear_p) begin
          time_d  = '0;
          state_d = S_IDLE;
        end else if (stop_p || !bus.door_closed) begin
          state_d = S_PAUSE;
        end else if (tick_wrap) begin
          tick_d  = '0;
          time_d  = time_dec;
          phase_d = phase_next;
          if (time_dec == '0) begin
            beep_cnt_d = '0;
            state_d    = S_DONE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_PAUSE: begin
        if (clear_p || stop_p) begin
          time_d  = '0;
          state_d = S_IDLE;
        end else if (start_p && bus.door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (clear_p || stop_p || key_p) begin
          time_d  = '0;
          state_d = S_IDLE;
        end else if (tick_wrap) begin
          tick_d = '0;
          if (beep_cnt_q == BW'(BEEP_TICKS - 1)) begin
            time_d  = '0;
            state_d = S_IDLE;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from next-state values so they switch on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      time_q       <= '0;
      tick_q       <= '0;
      phase_q      <= '0;
      level_q      <= '0;
      beep_cnt_q   <= '0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
      key_prev_q   <= 1'b0;
      mag_q        <= 1'b0;
      cooking_q    <= 1'b0;
      paused_q     <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      level_q      <= level_d;
      beep_cnt_q   <= beep_cnt_d;
      start_prev_q <= bus.startn;
      stop_prev_q  <= bus.stopn;
      clear_prev_q <= bus.clearn;
      key_prev_q   <= |bus.keypad;
      mag_q        <= (state_d == S_COOK) && (phase_d < level_d) && bus.door_closed;
      cooking_q    <= (state_d == S_COOK);
      paused_q     <= (state_d == S_PAUSE);
      beep_q       <= (state_d == S_DONE);
    end
  end

  assign bus.time_bcd  = time_q;
  assign bus.mag_on    = mag_q;
  assign bus.cooking   = cooking_q;
  assign bus.paused    = paused_q;
  assign bus.beep      = beep_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_microwave_ctrl_p.sv
// Directed plus randomized checks of microwave_ctrl_p against a min:sec reference model
// driven by elapsed cook cycles.
module tb_microwave_ctrl_p;

  localparam int DIGITS = 4;
  localparam int TD     = 4;
  localparam int PL     = 10;
  localparam int BT     = 3;
  localparam int QT     = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  microwave_ctrl_p_if #(.DIGITS(DIGITS)) bus ();

  microwave_ctrl_p #(
    .DIGITS(DIGITS), .TICK_DIV(TD), .POWER_LEVELS(PL),
    .BEEP_TICKS(BT), .QUICK_SECS_TENS(QT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  int val_m  = 0;   // entered digits as a decimal number, last DIGITS digits kept
  int min_m, sec_m, lvl_m, cook_n;
  int mag_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int mn, input int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_key(input int d);
    bus.keypad = 10'(1 << d);
    tick();
    bus.keypad = '0;
    tick();
    val_m = (val_m * 10 + d) % 10000;
  endtask

  task automatic press_clear();
    bus.clearn = 1'b0;
    tick();
    bus.clearn = 1'b1;
    val_m = 0;
    chk("clear_time", 32'(bus.time_bcd), 32'h0);
    chk("clear_cooking", 32'(bus.cooking), 32'h0);
    chk("clear_mag", 32'(bus.mag_on), 32'h0);
  endtask

  task automatic start_cook(input int req);
    bus.power_level = 4'(req);
    bus.startn = 1'b0;
    tick();
    bus.startn = 1'b1;
    if (val_m == 0) begin
      min_m = 0; sec_m = QT * 10; lvl_m = PL;
    end else begin
      min_m = val_m / 100; sec_m = val_m % 100;
      lvl_m = (req > PL) ? PL : req;
    end
    cook_n = 0;
    chk("start_cooking", 32'(bus.cooking), 32'h1);
    chk("start_time", 32'(bus.time_bcd), 32'(bcd(min_m, sec_m)));
    chk("start_mag", 32'(bus.mag_on), 32'(lvl_m > 0));
  endtask

  // Advances the model by whole cook cycles: one second per TD cycles, phase = seconds mod PL.
  task automatic run_cook(input int n);
    bit done;
    bit mag_e;
    for (int i = 0; i < n; i++) begin
      tick();
      cook_n++;
      if (cook_n % TD == 0) begin
        if (sec_m > 0) sec_m--;
        else begin sec_m = 59; min_m--; end
      end
      done  = (min_m == 0 && sec_m == 0);
      mag_e = !done && (((cook_n / TD) % PL) < lvl_m);
      if (bus.mag_on) mag_hi++;
      chk("cook_time", 32'(bus.time_bcd), 32'(bcd(min_m, sec_m)));
      chk("cook_cooking", 32'(bus.cooking), 32'(!done));
      chk("cook_beep", 32'(bus.beep), 32'(done));
      chk("cook_mag", 32'(bus.mag_on), 32'(mag_e));
    end
  endtask

  initial begin
    int total, nt, extra;
    bus.keypad      = '0;
    bus.power_level = 4'd10;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_time", 32'(bus.time_bcd), 32'h0);
    chk("rst_mag", 32'(bus.mag_on), 32'h0);
    chk("rst_cooking", 32'(bus.cooking), 32'h0);
    chk("rst_paused", 32'(bus.paused), 32'h0);
    chk("rst_beep", 32'(bus.beep), 32'h0);

    // keys 1,0,5 then full-power cook down past the minute boundary
    press_key(1); press_key(0); press_key(5);
    chk("entry_105", 32'(bus.time_bcd), 32'h0105);
    start_cook(10);
    run_cook(4);
    chk("after4_0104", 32'(bus.time_bcd), 32'h0104);
    run_cook(20);
    chk("after24_0059", 32'(bus.time_bcd), 32'h0059);
    press_clear();

    // quick-start, countdown to DONE, beep window, return to IDLE
    start_cook(2);
    chk("quick_0030", 32'(bus.time_bcd), 32'h0030);
    run_cook(30 * TD);
    chk("done_beep", 32'(bus.beep), 32'h1);
    for (int k = 1; k <= TD * BT; k++) begin
      tick();
      chk("beep_window", 32'(bus.beep), 32'(k < TD * BT));
      chk("beep_time", 32'(bus.time_bcd), 32'h0);
      chk("beep_cooking", 32'(bus.cooking), 32'h0);
    end
    chk("beep_idle_mag", 32'(bus.mag_on), 32'h0);

    // power level 3: 3 of every 10 ticks on
    press_key(2); press_key(0); press_key(0);
    start_cook(3);
    mag_hi = 1;
    run_cook(40 * TD);
    chk("duty_3of10", 32'(mag_hi), 32'(12 * TD + 1));
    press_clear();

    // level 15 clamps to full power
    press_key(9);
    start_cook(15);
    run_cook(8 * TD);
    press_clear();

    // randomized entries and levels
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) press_key($urandom_range(0, 9));
      if (val_m == 0) press_key(1 + $urandom_range(0, 8));
      start_cook($urandom_range(0, 15));
      total = min_m * 60 + sec_m;
      nt    = (total - 1 < 20) ? total - 1 : 20;
      extra = $urandom_range(0, TD - 1);
      run_cook(nt * TD + extra);
      press_clear();
    end

    // door opened mid-cook at 0:42, then resume
    press_key(4); press_key(2);
    start_cook(10);
    run_cook(2);
    bus.door_closed = 1'b0;
    tick();
    chk("door_paused", 32'(bus.paused), 32'h1);
    chk("door_mag", 32'(bus.mag_on), 32'h0);
    chk("door_time", 32'(bus.time_bcd), 32'h0042);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pause_hold", 32'(bus.time_bcd), 32'h0042);
    end
    bus.door_closed = 1'b1;
    tick();
    chk("closed_still_paused", 32'(bus.paused), 32'h1);
    bus.startn = 1'b0;
    tick();
    bus.startn = 1'b1;
    chk("resume_cooking", 32'(bus.cooking), 32'h1);
    chk("resume_paused", 32'(bus.paused), 32'h0);
    chk("resume_mag", 32'(bus.mag_on), 32'h1);
    run_cook(2);
    chk("resume_0041", 32'(bus.time_bcd), 32'h0041);

    // start and clear together while cooking
    bus.startn = 1'b0;
    bus.clearn = 1'b0;
    tick();
    bus.startn = 1'b1;
    bus.clearn = 1'b1;
    val_m = 0;
    chk("sc_cooking", 32'(bus.cooking), 32'h0);
    chk("sc_time", 32'(bus.time_bcd), 32'h0);
    chk("sc_mag", 32'(bus.mag_on), 32'h0);

    // start with the door open in IDLE is ignored
    press_key(7);
    bus.door_closed = 1'b0;
    bus.startn = 1'b0;
    tick();
    bus.startn = 1'b1;
    tick();
    chk("dooropen_cooking", 32'(bus.cooking), 32'h0);
    chk("dooropen_time", 32'(bus.time_bcd), 32'h0007);
    bus.door_closed = 1'b1;
    press_clear();

    // five keys drop the oldest digit
    for (int d = 1; d <= 5; d++) press_key(d);
    chk("five_keys", 32'(bus.time_bcd), 32'h2345);

    // reset while cooking
    start_cook(7);
    run_cook(3);
    reset = 1'b1;
    tick();
    chk("rstcook_time", 32'(bus.time_bcd), 32'h0);
    chk("rstcook_mag", 32'(bus.mag_on), 32'h0);
    chk("rstcook_cooking", 32'(bus.cooking), 32'h0);
    chk("rstcook_paused", 32'(bus.paused), 32'h0);
    chk("rstcook_beep", 32'(bus.beep), 32'h0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
